// File: rtl/bcd_sched_pkg.sv
// Shared types and defaults for the BCD converter scheduler.
// Optional result cache: define BCD_CONV_SCHED_CACHE_EN.
package bcd_sched_pkg;
  localparam int VAL_W_DEF = 8;
  localparam int BCD_W_DEF = 12;
  localparam int DIGIT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;
endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin search: first valid requester at or above rr_ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_vld
);
  logic [2*NUM_REQ-1:0] rot;
  logic [PTR_W:0]       off;
  logic [PTR_W:0]       sum;

  always_comb begin
    // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins.
    rot     = {req_valid, req_valid} >> rr_ptr;
    off     = '0;
    gnt_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld = 1'b1;
        off     = (PTR_W+1)'(k);
      end
    end
    sum = {1'b0, rr_ptr} + off;
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    gnt_idx = sum[PTR_W-1:0];
  end
endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one iterative binary-to-BCD converter between NUM_REQ requesters, round-robin.
// Define BCD_CONV_SCHED_CACHE_EN to skip conversion when a requester repeats its last value.
module bcd_conv_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int VAL_W   = VAL_W_DEF,
  parameter int BCD_W   = BCD_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VAL_W-1:0] req_value,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       res_valid,
  output logic [NUM_REQ*BCD_W-1:0] res_bcd,
  output logic                     busy,
  output logic                     conv_start,
  output logic [VAL_W-1:0]         conv_value,
  input  logic                     conv_done,
  input  logic [BCD_W-1:0]         conv_bcd
);
  localparam int PTR_W = $clog2(NUM_REQ);

  state_t                          state_q, state_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                cur_idx_q, cur_idx_d;
  logic [VAL_W-1:0]                cur_val_q, cur_val_d;
  logic [NUM_REQ-1:0][BCD_W-1:0]   res_q, res_d;
  logic [NUM_REQ-1:0][VAL_W-1:0]   req_val_a;
  logic [PTR_W-1:0]                gnt_idx;
  logic                            gnt_vld;
`ifdef BCD_CONV_SCHED_CACHE_EN
  logic [NUM_REQ-1:0][VAL_W-1:0]   last_val_q, last_val_d;
  logic [NUM_REQ-1:0]              hit_q, hit_d;
`endif

  assign req_val_a  = req_value;
  assign res_bcd    = res_q;
  assign conv_value = cur_val_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_idx_q  <= '0;
      cur_val_q  <= '0;
      res_q      <= '0;
`ifdef BCD_CONV_SCHED_CACHE_EN
      last_val_q <= '0;
      hit_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_idx_q  <= cur_idx_d;
      cur_val_q  <= cur_val_d;
      res_q      <= res_d;
`ifdef BCD_CONV_SCHED_CACHE_EN
      last_val_q <= last_val_d;
      hit_q      <= hit_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_idx_d  = cur_idx_q;
    cur_val_d  = cur_val_q;
    res_d      = res_q;
`ifdef BCD_CONV_SCHED_CACHE_EN
    last_val_d = last_val_q;
    hit_d      = hit_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          cur_idx_d = gnt_idx;
          cur_val_d = req_val_a[gnt_idx];
          state_d   = START;
`ifdef BCD_CONV_SCHED_CACHE_EN
          if (hit_q[gnt_idx] && (req_val_a[gnt_idx] == last_val_q[gnt_idx]))
            state_d = WRITE;
`endif
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (conv_done) begin
          res_d[cur_idx_q] = conv_bcd;
          state_d          = WRITE;
        end
      end
      WRITE: begin
        rr_ptr_d = (cur_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : cur_idx_q + PTR_W'(1);
        state_d  = IDLE;
`ifdef BCD_CONV_SCHED_CACHE_EN
        // On a hit this rewrites the same value, so no separate miss flag is kept.
        last_val_d[cur_idx_q] = cur_val_q;
        hit_d[cur_idx_q]      = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    res_valid  = '0;
    conv_start = (state_q == START);
    busy       = (state_q != IDLE);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !reset && (state_q == IDLE) && gnt_vld && (gnt_idx == PTR_W'(i));
      res_valid[i] = (state_q == WRITE) && (cur_idx_q == PTR_W'(i));
    end
  end
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler with a 10-cycle converter model.
// Cache checks follow BCD_CONV_SCHED_CACHE_EN.
module tb_bcd_conv_scheduler;
  localparam int N   = 3;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, keep;
  logic [N*8-1:0] req_value;
  logic [N-1:0]  req_ready, res_valid;
  logic [N*12-1:0] res_bcd;
  logic          busy, conv_start, conv_done;
  logic [7:0]    conv_value;
  logic [11:0]   conv_bcd;
  logic          model_done, stray_done;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, start_cyc = 0, done_cyc = 0, rv_cyc = 0, n_start = 0;
  int rv_cnt[N];
  int order[$];
  int mcnt = 0;
  logic [7:0] mval;

  assign conv_done = model_done | stray_done;

  bcd_conv_scheduler #(.NUM_REQ(N), .VAL_W(8), .BCD_W(12)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_value(req_value),
    .req_ready(req_ready), .res_valid(res_valid), .res_bcd(res_bcd), .busy(busy),
    .conv_start(conv_start), .conv_value(conv_value), .conv_done(conv_done),
    .conv_bcd(conv_bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int h, t, o;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    return {h[3:0], t[3:0], o[3:0]};
  endfunction

  // Converter model, driven mid-cycle from the current conv_start.
  always @(posedge clk) begin
    #2;
    model_done = 1'b0;
    if (reset) mcnt = 0;
    else if (mcnt != 0) begin
      mcnt--;
      if (mcnt == 0) begin model_done = 1'b1; conv_bcd = to_bcd(mval); end
    end else if (conv_start) begin
      mcnt = LAT; mval = conv_value;
    end
  end

  always @(negedge clk) begin
    if (|(req_valid & req_ready)) acc_cyc = cyc;
    if (conv_start) begin n_start++; start_cyc = cyc; end
    if (conv_done) done_cyc = cyc;
    for (int i = 0; i < N; i++)
      if (res_valid[i]) begin rv_cnt[i]++; rv_cyc = cyc; order.push_back(i); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk); #1;
    req_valid = (req_valid & ~acc) | (acc & keep);
  endtask

  task automatic set_req(input int i, input logic [7:0] v);
    req_value[i*8 +: 8] = v;
    req_valid[i] = 1'b1;
  endtask

  function automatic logic [11:0] slice(input int i);
    return res_bcd[i*12 +: 12];
  endfunction

  function automatic int rv_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += rv_cnt[i];
    return s;
  endfunction

  task automatic do_reset();
    req_valid = '0; keep = '0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_rv(input string tag, input int i, input int target);
    int n = 0;
    while (rv_cnt[i] < target && n < 200) begin tick(); n++; end
    chk(tag, rv_cnt[i], target);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || req_valid != '0) && n < 300) begin tick(); n++; end
    tick();
    chk("idle", {31'd0, busy}, 32'd0);
  endtask

  int base, b0, b1, b2, s0;

  initial begin
    for (int i = 0; i < N; i++) rv_cnt[i] = 0;
    stray_done = 1'b0; model_done = 1'b0; conv_bcd = '0; req_value = '0;
    req_valid = '0; keep = '0; reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {29'd0, req_ready}, 32'd0);
    set_req(0, 8'd1);
    @(negedge clk);
    chk("rst_ready_req", {29'd0, req_ready}, 32'd0);
    req_valid = '0;
    do_reset();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_bcd", res_bcd, 0);
    chk("rst_start", {31'd0, conv_start}, 0);
    chk("rst_value", {24'd0, conv_value}, 0);
    chk("rst_rv", {29'd0, res_valid}, 0);

    // Single request
    set_req(0, 8'd255);
    wait_rv("single_rv", 0, 1);
    chk("single_start_lat", start_cyc - acc_cyc, 1);
    chk("single_rv_lat", rv_cyc - done_cyc, 1);
    chk("single_bcd0", {20'd0, slice(0)}, 32'h255);
    chk("single_bcd12", {8'd0, res_bcd[35:12]}, 0);
    wait_idle();

    // Three simultaneous requests
    do_reset();
    base = order.size(); b0 = rv_cnt[0]; b1 = rv_cnt[1]; b2 = rv_cnt[2];
    set_req(0, 8'd7); set_req(1, 8'd42); set_req(2, 8'd199);
    wait_rv("all_rv2", 2, b2 + 1);
    wait_idle();
    chk("all_order0", order[base], 0);
    chk("all_order1", order[base+1], 1);
    chk("all_order2", order[base+2], 2);
    chk("all_cnt0", rv_cnt[0] - b0, 1);
    chk("all_cnt1", rv_cnt[1] - b1, 1);
    chk("all_cnt2", rv_cnt[2] - b2, 1);
    chk("all_bcd0", {20'd0, slice(0)}, 32'h007);
    chk("all_bcd1", {20'd0, slice(1)}, 32'h042);
    chk("all_bcd2", {20'd0, slice(2)}, 32'h199);
    chk("all_rrptr", {30'd0, dut.rr_ptr_q}, 0);

    // Fairness: requester 0 keeps asking while 2 waits
    do_reset();
    base = order.size(); b2 = rv_cnt[2];
    keep[0] = 1'b1;
    set_req(0, 8'd5); set_req(2, 8'd9);
    wait_rv("fair_rv2", 2, b2 + 1);
    keep = '0;
    wait_idle();
    chk("fair_first", order[base], 0);
    chk("fair_second", order[base+1], 2);
    chk("fair_bcd2", {20'd0, slice(2)}, 32'h009);
    chk("fair_bcd0", {20'd0, slice(0)}, 32'h005);

    // Reset during WAIT clears held results
    b1 = rv_total();
    set_req(1, 8'd88);
    for (int k = 0; k < 4; k++) tick();
    chk("wait_busy", {31'd0, busy}, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_bcd", res_bcd, 0);
    chk("midrst_value", {24'd0, conv_value}, 0);
    stray_done = 1'b1; tick(); stray_done = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("midrst_norv", rv_total() - b1, 0);
    b1 = rv_cnt[1];
    set_req(1, 8'd88);
    wait_rv("after_rst_rv", 1, b1 + 1);
    chk("after_rst_bcd1", {20'd0, slice(1)}, 32'h088);
    wait_idle();

    // Spurious conv_done in IDLE
    b1 = rv_total();
    stray_done = 1'b1; tick(); stray_done = 1'b0;
    tick();
    chk("stray_busy", {31'd0, busy}, 0);
    chk("stray_norv", rv_total() - b1, 0);
    chk("stray_bcd1", {20'd0, slice(1)}, 32'h088);

    // Repeated value on requester 1
    do_reset();
    b1 = rv_cnt[1];
    set_req(1, 8'd100);
    wait_rv("rep_first", 1, b1 + 1);
    wait_idle();
    s0 = n_start;
    set_req(1, 8'd100);
    wait_rv("rep_second", 1, b1 + 2);
    wait_idle();
    chk("rep_bcd1", {20'd0, slice(1)}, 32'h100);
`ifdef BCD_CONV_SCHED_CACHE_EN
    chk("cache_nostart", n_start - s0, 0);
    chk("cache_rv_lat", rv_cyc - acc_cyc, 1);
    do_reset();
    s0 = n_start; b1 = rv_cnt[1];
    set_req(1, 8'd100);
    wait_rv("cache_rst_rv", 1, b1 + 1);
    wait_idle();
    chk("cache_rst_start", n_start - s0, 1);
    chk("cache_rst_bcd1", {20'd0, slice(1)}, 32'h100);
`else
    chk("nocache_start", n_start - s0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
